// File: rtl/xor_matrix_pkg.sv
// xor_matrix_pkg
// Shared definitions for xor_matrix_seq: operation-select encodings, the
// controller state type and the result-count width helper.
package xor_matrix_pkg;

  localparam logic [1:0] MODE_XOR  = 2'b00;
  localparam logic [1:0] MODE_XNOR = 2'b01;
  localparam logic [1:0] MODE_AND  = 2'b10;
  localparam logic [1:0] MODE_OR   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Bits needed to count every bit of an na x nb matrix (0 .. na*nb).
  function automatic int cnt_width(input int na, input int nb);
    return $clog2(na * nb + 1);
  endfunction

endpackage

// File: rtl/xor_row_unit.sv
// xor_row_unit
// Combinational row generator: applies the selected bitwise operation between
// one row-operand bit and the whole column-operand vector, and counts the
// ones in the resulting row.
// Ports:
//   i_a_bit  one captured row-operand bit
//   i_b      captured column operand (NB bits)
//   i_mode   operation select (XOR / XNOR / AND / OR)
//   o_row    NB-bit result row
//   o_pop    number of ones in o_row
module xor_row_unit
  import xor_matrix_pkg::*;
#(
  parameter  int NB = 8,
  localparam int PW = $clog2(NB + 1)
) (
  input  logic          i_a_bit,
  input  logic [NB-1:0] i_b,
  input  logic [1:0]    i_mode,
  output logic [NB-1:0] o_row,
  output logic [PW-1:0] o_pop
);

  logic [NB-1:0] w_a_vec;

  assign w_a_vec = {NB{i_a_bit}};

  always_comb begin
    o_row = '0;
    case (i_mode)
      MODE_XOR:  o_row = w_a_vec ^ i_b;
      MODE_XNOR: o_row = ~(w_a_vec ^ i_b);
      MODE_AND:  o_row = w_a_vec & i_b;
      MODE_OR:   o_row = w_a_vec | i_b;
      default:   o_row = '0;
    endcase
  end

  always_comb begin
    o_pop = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      o_pop = o_pop + PW'(o_row[i]);
    end
  end

endmodule

// File: rtl/xor_matrix_seq.sv
// xor_matrix_seq
// Sequential outer-product engine: captures a_i, b_i and mode_i on a
// valid/ready handshake, builds the NA x NB matrix c[NB*i+j] = op(a[i], b[j])
// R rows per clock, accumulates its population count, then presents the
// result with out_valid_o until the consumer takes it.
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   a_i, b_i     row / column operands
//   mode_i       00 XOR, 01 XNOR, 10 AND, 11 OR
//   in_valid_i / in_ready_o    operand handshake
//   c_o          result matrix, row i at bits [NB*i +: NB]
//   cnt_o        number of ones in c_o
//   out_valid_o / out_ready_i  result handshake
module xor_matrix_seq
  import xor_matrix_pkg::*;
#(
  parameter  int NA = 8,
  parameter  int NB = 8,
  parameter  int R  = 1,
  localparam int CW = cnt_width(NA, NB)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [NA-1:0]    a_i,
  input  logic [NB-1:0]    b_i,
  input  logic [1:0]       mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [NA*NB-1:0] c_o,
  output logic [CW-1:0]    cnt_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int NG = NA / R;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int PW = $clog2(NB + 1);

  if ((NA % R) != 0) begin : g_bad_r
    $error("xor_matrix_seq: NA must be a multiple of R");
  end

  state_t r_state, w_next;
  logic   w_in_ready, w_accept, w_last;

  // Operands and result are stored group-major so group g holds rows g*R .. g*R+R-1.
  logic [NG-1:0][R-1:0]         r_a;
  logic [NB-1:0]                r_b;
  logic [1:0]                   r_mode;
  logic [GW-1:0]                r_g;
  logic [NG-1:0][R-1:0][NB-1:0] r_c;
  logic [CW-1:0]                r_cnt;

  logic [R-1:0]                 w_a_grp;
  logic [R-1:0][NB-1:0]         w_rows;
  logic [R-1:0][PW-1:0]         w_pop;
  logic [CW-1:0]                w_grp_pop;

  // Group selection by compare-loop keeps index widths exact even when NG == 1.
  always_comb begin
    w_a_grp = '0;
    for (int unsigned g = 0; g < NG; g++) begin
      if (r_g == GW'(g)) w_a_grp = r_a[g];
    end
  end

  for (genvar r = 0; r < R; r++) begin : g_row
    xor_row_unit #(.NB(NB)) u_row (
      .i_a_bit (w_a_grp[r]),
      .i_b     (r_b),
      .i_mode  (r_mode),
      .o_row   (w_rows[r]),
      .o_pop   (w_pop[r])
    );
  end

  always_comb begin
    w_grp_pop = '0;
    for (int unsigned i = 0; i < R; i++) begin
      w_grp_pop = w_grp_pop + CW'(w_pop[i]);
    end
  end

  assign w_last = (r_g == GW'(NG - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid_i) w_next = CALC;
      end
      CALC: begin
        if (w_last) w_next = HOLD;
      end
      HOLD: begin
        w_in_ready = out_ready_i;
        if (out_ready_i) w_next = in_valid_i ? CALC : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = in_valid_i && w_in_ready;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= '0;
      r_g    <= '0;
      r_c    <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a    <= a_i;
      r_b    <= b_i;
      r_mode <= mode_i;
      r_g    <= '0;
      r_c    <= '0;
      r_cnt  <= '0;
    end else if (r_state == CALC) begin
      for (int unsigned g = 0; g < NG; g++) begin
        if (r_g == GW'(g)) r_c[g] <= w_rows;
      end
      r_cnt <= r_cnt + w_grp_pop;
      r_g   <= w_last ? '0 : r_g + GW'(1);
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = (r_state == HOLD);
  assign c_o         = r_c;
  assign cnt_o       = r_cnt;

endmodule

// File: tb/tb_xor_matrix_seq.sv
module tb_xor_matrix_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0][15:0] a_s, b_s;
  logic [1:0][1:0]  md;
  logic [1:0]       vld, ordy, rdy, ov;
  logic [1:0][63:0] c;
  logic [1:0][6:0]  cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // d=0: defaults (NA=8, NB=8, R=1); d=1: NA=4, NB=16, R=4
  xor_matrix_seq u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .a_i(a_s[0][7:0]), .b_i(b_s[0][7:0]),
    .mode_i(md[0]), .in_valid_i(vld[0]), .in_ready_o(rdy[0]), .c_o(c[0]),
    .cnt_o(cnt[0]), .out_valid_o(ov[0]), .out_ready_i(ordy[0])
  );

  xor_matrix_seq #(.NA(4), .NB(16), .R(4)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .a_i(a_s[1][3:0]), .b_i(b_s[1]),
    .mode_i(md[1]), .in_valid_i(vld[1]), .in_ready_o(rdy[1]), .c_o(c[1]),
    .cnt_o(cnt[1]), .out_valid_o(ov[1]), .out_ready_i(ordy[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Outer product straight from the definition c[nb*i+j] = op(a[i], b[j]).
  function automatic logic [63:0] outer(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] m, input int na, input int nb);
    logic [63:0] res;
    logic        x;
    res = '0;
    for (int i = 0; i < na; i++) begin
      for (int j = 0; j < nb; j++) begin
        case (m)
          2'b00:   x = a[i] ^ b[j];
          2'b01:   x = ~(a[i] ^ b[j]);
          2'b10:   x = a[i] & b[j];
          default: x = a[i] | b[j];
        endcase
        res[nb*i+j] = x;
      end
    end
    return res;
  endfunction

  // Transaction-level model: cycles of work remaining, and whether a result is on offer.
  int          left[2] = '{0, 0};
  bit          hold[2] = '{0, 0};
  logic [63:0] ec[2];
  int          ecnt[2];
  int          acc1 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        left[d] <= 0;
        hold[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int          l;
        bit          h, er, take;
        logic [63:0] r;
        l    = left[d];
        h    = hold[d];
        er   = h ? ordy[d] : (l == 0);
        take = vld[d] && er;
        if (h && ordy[d]) h = 1'b0;
        if (l > 0) begin
          l = l - 1;
          if (l == 0) h = 1'b1;
        end
        if (take) begin
          l = (d == 1) ? 1 : 8;
          r = outer(a_s[d], b_s[d], md[d], (d == 1) ? 4 : 8, (d == 1) ? 16 : 8);
          ec[d]   <= r;
          ecnt[d] <= $countones(r);
          if (d == 1) acc1 <= acc1 + 1;
        end
        left[d] <= l;
        hold[d] <= h;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        check($sformatf("d%0d_rst_ready", d), 64'(rdy[d]), 64'd1);
        check($sformatf("d%0d_rst_valid", d), 64'(ov[d]), 64'd0);
        check($sformatf("d%0d_rst_c", d), c[d], 64'd0);
        check($sformatf("d%0d_rst_cnt", d), 64'(cnt[d]), 64'd0);
      end else begin
        check($sformatf("d%0d_in_ready", d), 64'(rdy[d]),
              64'(hold[d] ? ordy[d] : (left[d] == 0)));
        check($sformatf("d%0d_out_valid", d), 64'(ov[d]), 64'(hold[d]));
        if (hold[d]) begin
          check($sformatf("d%0d_c", d), c[d], ec[d]);
          check($sformatf("d%0d_cnt", d), 64'(cnt[d]), 64'(ecnt[d]));
        end
      end
    end
  end

  task automatic start(input int d, input logic [15:0] a, input logic [15:0] b, input logic [1:0] m);
    int t;
    @(posedge clk); #1;
    a_s[d] = a; b_s[d] = b; md[d] = m; vld[d] = 1'b1;
    t = 0;
    while (!rdy[d] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_wait", 64'(t < 100), 64'd1);
    @(posedge clk); #1;
    vld[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov[d] && lat < 100);
  endtask

  task automatic pin(input int d, input string name, input logic [63:0] ce, input int ne);
    check({name, "_c"}, c[d], ce);
    check({name, "_cnt"}, 64'(cnt[d]), 64'(ne));
  endtask

  initial begin
    int lat, cyc, base;
    rst_n = 1'b0;
    a_s = '0; b_s = '0; md = '0; vld = '0; ordy = '0;
    #3;
    for (int d = 0; d < 2; d++) begin
      check("reset_valid", 64'(ov[d]), 64'd0);
      check("reset_ready", 64'(rdy[d]), 64'd1);
      check("reset_c", c[d], 64'd0);
      check("reset_cnt", 64'(cnt[d]), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ordy[0] = 1'b1;

    // XOR with defaults
    start(0, 16'hF0, 16'h0F, 2'b00);
    wait_valid(0, lat);
    check("xor_latency", 64'(lat), 64'd8);
    pin(0, "xor", 64'hF0F0F0F00F0F0F0F, 32);

    // AND then XNOR accepted on the consume edge
    start(0, 16'hFF, 16'h01, 2'b10);
    wait_valid(0, lat);
    check("and_latency", 64'(lat), 64'd8);
    pin(0, "and", 64'h0101010101010101, 8);
    a_s[0] = 16'h00; b_s[0] = 16'h00; md[0] = 2'b01; vld[0] = 1'b1;
    check("b2b_ready", 64'(rdy[0]), 64'd1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    check("b2b_valid_drop", 64'(ov[0]), 64'd0);
    wait_valid(0, lat);
    check("xnor_latency", 64'(lat), 64'd8);
    pin(0, "xnor", 64'hFFFFFFFFFFFFFFFF, 64);

    // Back-pressure with toggling inputs
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    start(0, 16'h3C, 16'hA5, 2'b11);
    wait_valid(0, lat);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      a_s[0] = 16'($urandom); b_s[0] = 16'($urandom); vld[0] = 1'($urandom);
      check("bp_ready", 64'(rdy[0]), 64'd0);
      check("bp_valid", 64'(ov[0]), 64'd1);
    end
    vld[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 64'(ov[0]), 64'd0);

    // Reset during the 4th CALC cycle
    start(0, 16'hAA, 16'h55, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(ov[0]), 64'd0);
    check("midrst_ready", 64'(rdy[0]), 64'd1);
    pin(0, "midrst", 64'd0, 0);
    #1;
    rst_n = 1'b1;
    start(0, 16'hAA, 16'h55, 2'b00);
    wait_valid(0, lat);
    check("after_rst_latency", 64'(lat), 64'd8);
    pin(0, "after_rst", 64'hAA55AA55AA55AA55, 32);

    // NA=4, NB=16, R=4: single-edge latency, then randomised sweep
    ordy[1] = 1'b1;
    start(1, 16'h000A, 16'h00FF, 2'b00);
    wait_valid(1, lat);
    check("wide_latency", 64'(lat), 64'd1);
    pin(1, "wide", 64'hFF0000FFFF0000FF, 32);

    @(posedge clk); #1;
    base = acc1;
    cyc  = 0;
    while ((acc1 - base) < 10000 && cyc < 80000) begin
      @(posedge clk); #1;
      a_s[1]  = 16'($urandom);
      b_s[1]  = 16'($urandom);
      md[1]   = 2'($urandom);
      vld[1]  = ($urandom_range(0, 3) != 0);
      ordy[1] = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    check("sweep_count", 64'((acc1 - base) >= 10000), 64'd1);
    vld = '0;
    ordy = '1;
    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_matrix_seq.md
# xor_matrix_seq

Sequential, parametrised successor to the combinational XOR outer-product block. It computes an NA×NB bit matrix c[NB*i+j] = op(a[i], b[j]) under a runtime-selectable bitwise operation, R rows per clock. It also produces the population count of the result matrix. It sits between a valid/ready producer and consumer in the datapath test harness and replaces free-running combinational outer products where registered, back-pressured results are needed.

## Interface
- NA, 8, width of a_i (matrix rows)
- NB, 8, width of b_i (matrix columns)
- R, 1, rows computed per cycle; NA % R == 0 is required, and an elaboration-time check fails otherwise
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset; asynchronous and active-low
- a_i  in  NA  row operand
- b_i  in  NB  column operand
- mode_i  in  2  operation select: 00 XOR, 01 XNOR, 10 AND, 11 OR
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  block can accept operands
- c_o  out  NA*NB  result matrix, row i occupies bits [NB*i+NB-1 : NB*i]
- cnt_o  out  CW  number of 1 bits in c_o, where CW = $clog2(NA*NB+1)
- out_valid_o  out  1  c_o and cnt_o are valid
- out_ready_i  in  1  consumer accepts the result

## Operation
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - in_ready_o = 1.
  - When in_valid_i is high, the block captures a_i, b_i and mode_i into internal registers.
  - On the same edge it clears c_o and cnt_o, sets row index k = 0 and moves to CALC.
- CALC:
  - in_ready_o = 0.
  - Each cycle it writes rows k .. k+R-1 of c_o from the captured operands.
  - It adds the popcount of those R*NB bits to cnt_o, then sets k += R.
  - After writing the last group (k+R == NA) it moves to HOLD.
  - Captured operands and mode are immune to input changes during CALC.
- HOLD:
  - out_valid_o = 1; c_o and cnt_o are held stable.
  - in_ready_o = out_ready_i, so a back-to-back accept is possible.
  - If out_ready_i is high and in_valid_i is low, the block returns to IDLE.
  - If out_ready_i and in_valid_i are both high, the result is consumed and new operands are captured on the same edge. The block then goes directly to CALC, and c_o and cnt_o are cleared.
  - If out_ready_i is low, the block stays in HOLD with no output change.
- c_o and cnt_o carry partial content during CALC. Consumers and the checker must sample them only while out_valid_o is high.
- Width rule: the cnt_o accumulator is CW bits and cannot overflow (maximum NA*NB). Each per-group popcount is zero-extended to CW.
- Reset, asserted at any time including mid-CALC:
  - The state returns to IDLE immediately and the in-flight result is discarded.
  - Output values during reset: in_ready_o = 1 (IDLE), out_valid_o = 0, c_o = 0, cnt_o = 0, k = 0.

## Timing
- Accepting edge: in_valid_i && in_ready_o at a rising clock edge.
- out_valid_o rises exactly NA/R edges after the accepting edge. With defaults that is 8 edges; with R = NA it is 1 edge.
- Sustained throughput is one result per NA/R + 1 cycles with out_ready_i held high. The extra cycle is the HOLD handshake.
- No combinational path from a_i, b_i or mode_i to any output.
- The only combinational input-to-output path is out_ready_i to in_ready_o, and only in HOLD.
- out_valid_o deasserts on the edge after the consuming handshake unless a new result completes; completion cannot occur on that edge by construction.

## Structure
- Package xor_matrix_pkg holds:
  - mode constants MODE_XOR = 2'b00, MODE_XNOR = 2'b01, MODE_AND = 2'b10, MODE_OR = 2'b11;
  - the FSM state typedef;
  - a cnt_width(na, nb) function returning $clog2(na*nb+1).
- Sub-module xor_row_unit is combinational, instantiated R times:
  - inputs: one captured a bit, the captured b vector, and mode;
  - outputs: an NB-bit row and its popcount.
- The top level holds the FSM, the operand registers, the row index, the c_o and cnt_o registers and the handshake logic.

## Test plan
- Reset check: assert rst_n_i low -> out_valid_o = 0, in_ready_o = 1, c_o = 0, cnt_o = 0, all immediately without a clock edge.
- XOR, defaults: a = 8'hF0, b = 8'h0F, mode 00, out_ready_i held high -> out_valid_o exactly 8 edges after accept, c_o = 64'hF0F0F0F00F0F0F0F, cnt_o = 32.
- AND, then XNOR back-to-back with out_ready_i high:
  - first transaction a = 8'hFF, b = 8'h01 -> c_o = 64'h0101010101010101, cnt_o = 8;
  - second transaction a = 8'h00, b = 8'h00 is accepted on the consume edge -> c_o = all ones, cnt_o = 64.
- Back-pressure: hold out_ready_i low for 20 cycles while in HOLD and toggle a_i, b_i and in_valid_i -> c_o and cnt_o stable, in_ready_o = 0, no extra accept.
- Mid-operation reset: pulse rst_n_i low during the 4th CALC cycle, then run a = 8'hAA, b = 8'h55 XOR -> no out_valid_o for the aborted job, new result c_o = 64'hAA55AA55AA55AA55 (row pattern), cnt_o = 32.
- Parameter sweep: NA = 4, NB = 16, R = 4 with random operands and modes against a reference-model outer product -> latency 1 edge, c_o and cnt_o exact for 10 000 transactions with randomised out_ready_i.
